// File: rtl/dbg_pkg.sv
// Shared definitions for the register-file debug dump engine.
package dbg_pkg;

   localparam int unsigned DBG_DATA_W   = 8;
   localparam int unsigned DBG_ADDR_W   = 3;
   localparam int unsigned DBG_NUM_REGS = 8;
   localparam int unsigned SETTLE_W     = 3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_SEND_LO = 3'd4,
      ST_SEND_HI = 3'd5,
      ST_FINISH  = 3'd6
   } dump_state_e;

endpackage

// File: rtl/dump_out_buf.sv
// Two-entry capture buffer for one register pair plus the stream output stage.
// The data register itself serves as the low entry; buf_hi waits for the second beat.
module dump_out_buf #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              advance,
   input  logic              drop,
   input  logic [DATA_W-1:0] lo_in,
   input  logic [DATA_W-1:0] hi_in,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] buf_hi;

   // Latch the pair, present low then high, retire on the second handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_hi <= '0;
         data   <= '0;
         valid  <= 1'b0;
      end else if (capture) begin
         buf_hi <= hi_in;
         data   <= lo_in;
         valid  <= 1'b1;
      end else if (advance) begin
         data   <= buf_hi;
      end else if (drop) begin
         valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: freezes register writes, reads the 8x8 register file
// pairwise through both read ports and streams (address, data) beats.
module reg_dump_reader
   import dbg_pkg::*;
#(
   parameter int unsigned DATA_W        = DBG_DATA_W,
   parameter int unsigned ADDR_W        = DBG_ADDR_W,
   parameter int unsigned NUM_REGS      = DBG_NUM_REGS,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              HALT_ACK,
   output logic [ADDR_W-1:0] RADDR1,
   output logic [ADDR_W-1:0] RADDR2,
   input  logic [DATA_W-1:0] RDATA1,
   input  logic [DATA_W-1:0] RDATA2,
   output logic              HALT_REQ,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [ADDR_W-1:0] OUT_ADDR,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              BUSY,
   output logic              DONE
);

   localparam int unsigned            PAIR_W      = ADDR_W - 1;
   localparam logic [PAIR_W-1:0]      LAST_PAIR   = PAIR_W'(NUM_REGS / 2 - 1);
   localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

   dump_state_e         state;
   logic [PAIR_W-1:0]   pair;
   logic [PAIR_W-1:0]   pair_inc;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                fire_c;
   logic                capture_c;
   logic                advance_c;
   logic                drop_c;

   // Stream handshake and buffer control strobes.
   assign pair_inc  = pair + 1'b1;
   assign fire_c    = OUT_VALID & OUT_READY;
   assign capture_c = (state == ST_CAPTURE);
   assign advance_c = (state == ST_SEND_LO) & fire_c;
   assign drop_c    = (state == ST_SEND_HI) & fire_c;

   // Dump sequencer: halt handshake, per-pair settle/capture/send, completion pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= ST_IDLE;
         pair       <= '0;
         settle_cnt <= '0;
         RADDR1     <= '0;
         RADDR2     <= ADDR_W'(1);
         HALT_REQ   <= 1'b0;
         OUT_ADDR   <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  state    <= ST_HALT;
                  pair     <= '0;
                  RADDR1   <= '0;
                  RADDR2   <= ADDR_W'(1);
                  HALT_REQ <= 1'b1;
                  BUSY     <= 1'b1;
               end
            end
            ST_HALT: begin
               if (HALT_ACK) begin
                  state      <= ST_SETTLE;
                  settle_cnt <= '0;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_CAPTURE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_CAPTURE: begin
               state    <= ST_SEND_LO;
               OUT_ADDR <= {pair, 1'b0};
            end
            ST_SEND_LO: begin
               if (fire_c) begin
                  state    <= ST_SEND_HI;
                  OUT_ADDR <= {pair, 1'b1};
               end
            end
            ST_SEND_HI: begin
               if (fire_c) begin
                  if (pair == LAST_PAIR) begin
                     state    <= ST_FINISH;
                     DONE     <= 1'b1;
                     HALT_REQ <= 1'b0;
                  end else begin
                     state      <= ST_SETTLE;
                     pair       <= pair_inc;
                     settle_cnt <= '0;
                     RADDR1     <= {pair_inc, 1'b0};
                     RADDR2     <= {pair_inc, 1'b1};
                  end
               end
            end
            ST_FINISH: begin
               state <= ST_IDLE;
               BUSY  <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               HALT_REQ <= 1'b0;
               BUSY     <= 1'b0;
            end
         endcase
      end
   end

   dump_out_buf #(
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk     (CLK),
      .rst     (RESET),
      .capture (capture_c),
      .advance (advance_c),
      .drop    (drop_c),
      .lo_in   (RDATA1),
      .hi_in   (RDATA2),
      .valid   (OUT_VALID),
      .data    (OUT_DATA)
   );

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a register-file model feeds two instances
// (settle 1 and settle 3); outputs are sampled on the falling edge.
module tb_reg_dump_reader;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic       START3;
   logic       HALT_ACK;
   logic       OUT_READY;

   logic [2:0] RADDR1, RADDR2, OUT_ADDR;
   logic [7:0] RDATA1, RDATA2, OUT_DATA;
   logic       HALT_REQ, OUT_VALID, BUSY, DONE;

   logic [2:0] RADDR1_3, RADDR2_3, OUT_ADDR3;
   logic [7:0] RDATA1_3, RDATA2_3, OUT_DATA3;
   logic       HALT_REQ3, OUT_VALID3, BUSY3, DONE3;

   logic [7:0] regs [8];

   int n_cmp = 0;
   int n_err = 0;

   assign RDATA1   = regs[RADDR1];
   assign RDATA2   = regs[RADDR2];
   assign RDATA1_3 = regs[RADDR1_3];
   assign RDATA2_3 = regs[RADDR2_3];

   reg_dump_reader dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START),
      .HALT_ACK  (HALT_ACK),
      .RADDR1    (RADDR1),
      .RADDR2    (RADDR2),
      .RDATA1    (RDATA1),
      .RDATA2    (RDATA2),
      .HALT_REQ  (HALT_REQ),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_ADDR  (OUT_ADDR),
      .OUT_DATA  (OUT_DATA),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   reg_dump_reader #(.SETTLE_CYCLES(3)) dut3 (
      .CLK       (CLK),
      .RESET     (RESET),
      .START     (START3),
      .HALT_ACK  (HALT_ACK),
      .RADDR1    (RADDR1_3),
      .RADDR2    (RADDR2_3),
      .RDATA1    (RDATA1_3),
      .RDATA2    (RDATA2_3),
      .HALT_REQ  (HALT_REQ3),
      .OUT_VALID (OUT_VALID3),
      .OUT_READY (OUT_READY),
      .OUT_ADDR  (OUT_ADDR3),
      .OUT_DATA  (OUT_DATA3),
      .BUSY      (BUSY3),
      .DONE      (DONE3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One dump on the settle-1 instance; cycle 1 is the cycle after the START edge.
   task automatic run_dump(input int halt_delay, input bit stall, input bit poke5,
                           input bit extra_start, input int exp_done);
      logic [7:0] exp_v [8];
      int  beats;
      int  cyc;
      int  vk;
      bit  done_seen;
      bit  stalled_prev;
      for (int i = 0; i < 8; i++) exp_v[i] = regs[i];
      START     = 1'b1;
      HALT_ACK  = (halt_delay == 0);
      OUT_READY = 1'b1;
      @(negedge CLK);
      START        = 1'b0;
      cyc          = 1;
      beats        = 0;
      vk           = 0;
      done_seen    = 1'b0;
      stalled_prev = 1'b0;
      while (!done_seen && cyc < 200) begin
         if (DONE) begin
            done_seen = 1'b1;
            chk("done_cycle", cyc, exp_done);
            chk("halt_req_at_done", HALT_REQ, 1'b0);
            chk("busy_at_done", BUSY, 1'b1);
            chk("valid_at_done", OUT_VALID, 1'b0);
            chk("beats_total", beats, 8);
         end else begin
            chk("busy", BUSY, 1'b1);
            chk("halt_req", HALT_REQ, 1'b1);
            if (!HALT_ACK) begin
               chk("raddr1_in_halt", RADDR1, 3'd0);
               chk("raddr2_in_halt", RADDR2, 3'd1);
               chk("valid_in_halt", OUT_VALID, 1'b0);
            end
            if (stalled_prev) chk("valid_held", OUT_VALID, 1'b1);
            if (OUT_VALID) begin
               chk("beat_addr", OUT_ADDR, beats);
               chk("beat_data", OUT_DATA, exp_v[beats & 7]);
               if (poke5 && beats == 4) regs[5] = 8'hA5;
               if (stall) OUT_READY = ((vk % 4) == 0) || ((vk % 4) == 3);
               else       OUT_READY = 1'b1;
               vk++;
               stalled_prev = !OUT_READY;
               if (OUT_READY) beats++;
            end else begin
               stalled_prev = 1'b0;
            end
            HALT_ACK = (cyc >= 1 + halt_delay);
            START    = extra_start && (cyc == 10);
            @(negedge CLK);
            cyc++;
         end
      end
      if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
      START     = 1'b0;
      OUT_READY = 1'b1;
      @(negedge CLK);
      chk("busy_after_done", BUSY, 1'b0);
      chk("done_one_cycle", DONE, 1'b0);
      chk("halt_req_after", HALT_REQ, 1'b0);
   endtask

   initial begin
      int  cyc;
      int  beats;
      bit  hit;

      for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
      RESET     = 1'b1;
      START     = 1'b0;
      START3    = 1'b0;
      HALT_ACK  = 1'b0;
      OUT_READY = 1'b0;
      @(negedge CLK);
      @(negedge CLK);

      // Reset state
      chk("rst_raddr1", RADDR1, 3'd0);
      chk("rst_raddr2", RADDR2, 3'd1);
      chk("rst_halt_req", HALT_REQ, 1'b0);
      chk("rst_out_valid", OUT_VALID, 1'b0);
      chk("rst_out_addr", OUT_ADDR, 3'd0);
      chk("rst_out_data", OUT_DATA, 8'h00);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_busy3", BUSY3, 1'b0);
      RESET = 1'b0;
      @(negedge CLK);

      // Baseline with a stray START mid-dump that must be ignored
      run_dump(0, 1'b0, 1'b0, 1'b1, 18);

      // Register 5 rewritten after pair-2 capture; stream keeps 8'h15
      run_dump(0, 1'b0, 1'b1, 1'b0, 18);
      chk("reg5_poked", regs[5], 8'hA5);

      // Stall pattern 1,0,0,1 on OUT_READY; dump now sees 8'hA5 at register 5
      run_dump(0, 1'b1, 1'b0, 1'b0, 26);

      // HALT_ACK five cycles late
      run_dump(5, 1'b0, 1'b0, 1'b0, 23);

      // Reset while the pair-2 high beat is being offered
      START     = 1'b1;
      HALT_ACK  = 1'b1;
      OUT_READY = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      hit   = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         if (OUT_VALID && OUT_ADDR == 3'd5) hit = 1'b1;
         else @(negedge CLK);
      end
      chk("reached_pair2_hi", hit, 1'b1);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("mid_rst_valid", OUT_VALID, 1'b0);
      chk("mid_rst_halt_req", HALT_REQ, 1'b0);
      chk("mid_rst_busy", BUSY, 1'b0);
      chk("mid_rst_done", DONE, 1'b0);
      chk("mid_rst_raddr1", RADDR1, 3'd0);
      chk("mid_rst_raddr2", RADDR2, 3'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("post_rst_no_done", DONE, 1'b0);
         chk("post_rst_idle", BUSY, 1'b0);
      end

      // Fresh dump after the abandoned one starts again at register 0
      regs[5] = 8'h15;
      run_dump(0, 1'b0, 1'b0, 1'b0, 18);

      // Settle-3 instance: beat timing and total latency
      START3    = 1'b1;
      HALT_ACK  = 1'b1;
      OUT_READY = 1'b1;
      @(negedge CLK);
      START3 = 1'b0;
      cyc    = 1;
      beats  = 0;
      hit    = 1'b0;
      while (!hit && cyc < 200) begin
         if (DONE3) begin
            hit = 1'b1;
            chk("s3_done_cycle", cyc, 26);
            chk("s3_halt_req_at_done", HALT_REQ3, 1'b0);
            chk("s3_beats_total", beats, 8);
         end else begin
            if (OUT_VALID3) begin
               chk("s3_beat_addr", OUT_ADDR3, beats);
               chk("s3_beat_data", OUT_DATA3, regs[beats & 7]);
               chk("s3_beat_cycle", cyc, 6 + 6 * (beats / 2) + (beats % 2));
               beats++;
            end
            @(negedge CLK);
            cyc++;
         end
      end
      if (!hit) chk("s3_done_timeout", 32'd0, 32'd1);
      @(negedge CLK);
      chk("s3_busy_after", BUSY3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
